dcache_rsp_tracker: RTL and testbench
=====================================

DCACHE_RSP_TRACKER -- requirements
Module: dcache_rsp_tracker

Interface
REQ-001 The module SHALL have parameter TID_W, default 5, meaning width of the dcache transaction id (the destination register tag).
REQ-002 The module SHALL have parameter MAX_OUT, default 8, meaning the maximum number of outstanding dcache requests (power of two, at most 2^TID_W).
REQ-003 The module SHALL have port clk_i, input, 1 bit: the clock; reset is asynchronous and active-low on rstn_i, input, 1 bit.
REQ-004 The module SHALL have port req_fire_i, input, 1 bit: request accepted by dcache this cycle (core_req_valid && dcache ready).
REQ-005 The module SHALL have port req_tid_i, input, TID_W bits: tid of the accepted request.
REQ-006 The module SHALL have port req_size_i, input, 3 bits: mem_size[2:0] (bit2=unsigned, [1:0]=log2 bytes).
REQ-007 The module SHALL have port req_off_i, input, 3 bits: address bits [2:0].
REQ-008 The module SHALL have port req_fp_i, input, 1 bit: floating-point load (FLW/FLD).
REQ-009 The module SHALL have port rsp_valid_i, input, 1 bit; rsp_tid_i, input, TID_W bits; and rsp_data_i, input, 64 bits: raw dcache response.
REQ-010 The module SHALL have port can_issue_o, output, 1 bit: a new request may be issued.
REQ-011 The module SHALL have port out_valid_o, output, 1 bit; out_tid_o, output, TID_W bits; and out_data_o, output, 64 bits: aligned load result.
REQ-012 The module SHALL have port pending_o, output, $clog2(MAX_OUT)+1 bits: the outstanding count.
REQ-013 The module SHALL have port err_o, output, 1 bit: sticky protocol error.

Function
REQ-014 The module SHALL keep a table of 2^TID_W entries {busy, size, off, fp}; req_fire_i with entry free SHALL set busy and capture fields at the clock edge.
REQ-015 rsp_valid_i SHALL read the entry at rsp_tid_i; if busy, the module SHALL clear busy and, one cycle later, assert out_valid_o for exactly one cycle with out_tid_o=rsp_tid_i.
REQ-016 out_data_o SHALL be rsp_data_i >> (8*off), truncated to 1/2/4/8 bytes per size[1:0], zero-extended if size[2]=1, else sign-extended to 64 bits.
REQ-017 pending_o SHALL increment on a valid allocation, decrement on a valid free, and hold when both occur in the same cycle.
REQ-018 can_issue_o SHALL be combinational: (pending_o < MAX_OUT); an allocation at pending_o==MAX_OUT SHALL be dropped and set err_o.
REQ-019 An allocation to a busy tid SHALL be dropped (entry unchanged) and SHALL set err_o.
REQ-020 A response to a non-busy tid SHALL produce no out_valid_o and SHALL set err_o.
REQ-021 Same-cycle allocation and response on the same tid with the entry busy SHALL free the old entry, output with the old fields, and SHALL set err_o (the new allocation is dropped).
REQ-022 Same-cycle allocation and response on the same tid with the entry free SHALL produce an allocation only and SHALL set err_o (no bypass).
REQ-023 err_o SHALL remain set until reset.

Reset
REQ-024 On rstn_i low, asynchronously: all busy bits SHALL be 0, pending_o SHALL be 0, out_valid_o SHALL be 0, out_tid_o SHALL be 0, out_data_o SHALL be 0, err_o SHALL be 0, and can_issue_o SHALL be 1.
REQ-025 Reset asserted mid-operation SHALL discard all outstanding entries; responses arriving after reset release SHALL be treated as responses to non-busy tids.

Configuration
REQ-026 With DCACHE_RSP_NANBOX_EN defined, a completion with fp=1 and size[1:0]=2 SHALL output {32'hFFFFFFFF, word}; without it, the sign-extension rule of REQ-016 SHALL apply.

Verification
REQ-027 Alloc tid=3 size=3'b000 off=5, then rsp data=64'h0000_8000_0000_0000 -> the next cycle SHALL give out_valid=1, tid=3, data=64'hFFFF_FFFF_FFFF_FF80.
REQ-028 Alloc tid=4 size=3'b101 off=2, then rsp data=64'h0000_0000_ABCD_0000 -> out_data SHALL be 64'h0000_0000_0000_ABCD.
REQ-029 Alloc 8 distinct tids -> can_issue_o SHALL be 0 and pending_o SHALL be 8; a 9th alloc -> err_o=1 and pending_o SHALL stay 8.
REQ-030 With pending_o=2, alloc tid=7 and rsp tid=1 (busy) in the same cycle -> pending_o SHALL stay 2 and out_valid SHALL be 1 for tid=1.
REQ-031 Rsp tid=9 with no allocation -> out_valid SHALL stay 0 and err_o SHALL be 1 until reset.
REQ-032 With DCACHE_RSP_NANBOX_EN defined, fp=1 size=3'b010 off=4 data=64'h8765_4321_0000_0000 -> out_data SHALL be 64'hFFFF_FFFF_8765_4321.

Source files
------------

// File: rtl/dcache_rsp_tracker.sv
// Tracks outstanding dcache loads by tid and aligns/extends each returned word.
// Latency: a response is freed at the edge that samples it; out_* is valid the following cycle.
// Backpressure: can_issue_o drops when MAX_OUT loads are pending; there is no stall on out_*.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   req_fire_i/tid/size/off/fp  accepted request; allocates the tid's table entry
//   rsp_valid_i/tid/data   raw dcache response; frees the tid's entry
//   can_issue_o            combinational, pending_o < MAX_OUT
//   out_valid_o/tid/data   registered aligned load result, one-cycle pulse
//   pending_o              number of busy entries
//   err_o                  sticky protocol error (dropped alloc, orphan response)
// Optional: define DCACHE_RSP_NANBOX_EN to NaN-box single-precision FP loads.
module dcache_rsp_tracker #(
    parameter int TID_W   = 5,
    parameter int MAX_OUT = 8,
    localparam int DEPTH  = 1 << TID_W,
    localparam int CNT_W  = $clog2(MAX_OUT) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_fire_i,
    input  logic [TID_W-1:0] req_tid_i,
    input  logic [2:0]       req_size_i,
    input  logic [2:0]       req_off_i,
    input  logic             req_fp_i,
    input  logic             rsp_valid_i,
    input  logic [TID_W-1:0] rsp_tid_i,
    input  logic [63:0]      rsp_data_i,
    output logic             can_issue_o,
    output logic             out_valid_o,
    output logic [TID_W-1:0] out_tid_o,
    output logic [63:0]      out_data_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             err_o
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] fp_q;
    logic [2:0]       size_q [DEPTH];
    logic [2:0]       off_q  [DEPTH];
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             err_q, err_d;
    logic             out_valid_q;
    logic [TID_W-1:0] out_tid_q;
    logic [63:0]      out_data_q;

    logic        alloc_ok, free_ok;
    logic [2:0]  ent_size;
    logic [2:0]  ent_off;
    logic        ent_fp;
    logic [63:0] shifted;
    logic [63:0] aligned;
    logic        sx;

    assign can_issue_o = (pending_q < CNT_W'(MAX_OUT));

    // A same-tid alloc+rsp with the entry busy falls out naturally: the free
    // wins and the alloc is rejected because the entry is still busy this cycle.
    assign free_ok  = rsp_valid_i & busy_q[rsp_tid_i];
    assign alloc_ok = req_fire_i & ~busy_q[req_tid_i] & can_issue_o;

    always_comb begin
        busy_d = busy_q;
        if (free_ok)  busy_d[rsp_tid_i] = 1'b0;
        if (alloc_ok) busy_d[req_tid_i] = 1'b1;
    end

    always_comb begin
        pending_d = pending_q;
        case ({alloc_ok, free_ok})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    // Any rejected alloc or orphan response is an error; this also covers the
    // same-tid collisions in both the busy and free cases.
    assign err_d = err_q | (req_fire_i & ~alloc_ok) | (rsp_valid_i & ~free_ok);

    assign ent_size = size_q[rsp_tid_i];
    assign ent_off  = off_q[rsp_tid_i];
    assign ent_fp   = fp_q[rsp_tid_i];

    always_comb begin
        shifted = rsp_data_i >> {ent_off, 3'b000};
        aligned = shifted;
        sx      = 1'b0;
        case (ent_size[1:0])
            2'd0: begin
                sx      = ~ent_size[2] & shifted[7];
                aligned = {{56{sx}}, shifted[7:0]};
            end
            2'd1: begin
                sx      = ~ent_size[2] & shifted[15];
                aligned = {{48{sx}}, shifted[15:0]};
            end
            2'd2: begin
                sx      = ~ent_size[2] & shifted[31];
                aligned = {{32{sx}}, shifted[31:0]};
`ifdef DCACHE_RSP_NANBOX_EN
                if (ent_fp) aligned = {32'hFFFF_FFFF, shifted[31:0]};
`endif
            end
            default: aligned = shifted;
        endcase
    end

`ifndef DCACHE_RSP_NANBOX_EN
    // fp is tracked per entry but only consulted when NaN-boxing is built in.
    logic unused_fp;
    assign unused_fp = ent_fp;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_q      <= '0;
            pending_q   <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_tid_q   <= '0;
            out_data_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            out_valid_q <= free_ok;
            if (free_ok) begin
                out_tid_q  <= rsp_tid_i;
                out_data_q <= aligned;
            end
        end
    end

    // Entry fields are qualified by busy, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (alloc_ok) begin
            size_q[req_tid_i] <= req_size_i;
            off_q[req_tid_i]  <= req_off_i;
            fp_q[req_tid_i]   <= req_fp_i;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_tid_o   = out_tid_q;
    assign out_data_o  = out_data_q;
    assign pending_o   = pending_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dcache_rsp_tracker.sv
// Directed bench for dcache_rsp_tracker with hand-computed expected values.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// No backpressure; every scenario runs a fixed number of cycles.
module tb_dcache_rsp_tracker;

    localparam int TID_W   = 5;
    localparam int MAX_OUT = 8;
    localparam int CNT_W   = $clog2(MAX_OUT) + 1;

    logic             clk_i;
    logic             rstn_i;
    logic             req_fire_i;
    logic [TID_W-1:0] req_tid_i;
    logic [2:0]       req_size_i;
    logic [2:0]       req_off_i;
    logic             req_fp_i;
    logic             rsp_valid_i;
    logic [TID_W-1:0] rsp_tid_i;
    logic [63:0]      rsp_data_i;
    logic             can_issue_o;
    logic             out_valid_o;
    logic [TID_W-1:0] out_tid_o;
    logic [63:0]      out_data_o;
    logic [CNT_W-1:0] pending_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;

    dcache_rsp_tracker #(.TID_W(TID_W), .MAX_OUT(MAX_OUT)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_fire_i  (req_fire_i),
        .req_tid_i   (req_tid_i),
        .req_size_i  (req_size_i),
        .req_off_i   (req_off_i),
        .req_fp_i    (req_fp_i),
        .rsp_valid_i (rsp_valid_i),
        .rsp_tid_i   (rsp_tid_i),
        .rsp_data_i  (rsp_data_i),
        .can_issue_o (can_issue_o),
        .out_valid_o (out_valid_o),
        .out_tid_o   (out_tid_o),
        .out_data_o  (out_data_o),
        .pending_o   (pending_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        req_fire_i  = 1'b0;
        rsp_valid_i = 1'b0;
    endtask

    task automatic set_alloc(input int tid, input logic [2:0] size, input logic [2:0] off, input logic fp);
        req_fire_i = 1'b1;
        req_tid_i  = TID_W'(tid);
        req_size_i = size;
        req_off_i  = off;
        req_fp_i   = fp;
    endtask

    task automatic set_rsp(input int tid, input logic [63:0] data);
        rsp_valid_i = 1'b1;
        rsp_tid_i   = TID_W'(tid);
        rsp_data_i  = data;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        #2;
        rstn_i = 1'b1;
        #1;
    endtask

    initial begin
        rstn_i      = 1'b0;
        req_fire_i  = 1'b0;
        req_tid_i   = '0;
        req_size_i  = '0;
        req_off_i   = '0;
        req_fp_i    = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_tid_i   = '0;
        rsp_data_i  = '0;

        // Reset values
        #2;
        chk("rst_pending",   64'(pending_o),   64'd0);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_tid",   64'(out_tid_o),   64'd0);
        chk("rst_out_data",  out_data_o,       64'd0);
        chk("rst_err",       64'(err_o),       64'd0);
        chk("rst_can_issue", 64'(can_issue_o), 64'd1);
        rstn_i = 1'b1;
        tick();

        // Signed byte at offset 5
        set_alloc(3, 3'b000, 3'd5, 1'b0);
        tick();
        chk("sb_pending1", 64'(pending_o), 64'd1);
        set_rsp(3, 64'h0000_8000_0000_0000);
        tick();
        chk("sb_valid", 64'(out_valid_o), 64'd1);
        chk("sb_tid",   64'(out_tid_o),   64'd3);
        chk("sb_data",  out_data_o,       64'hFFFF_FFFF_FFFF_FF80);
        chk("sb_pending0", 64'(pending_o), 64'd0);
        tick();
        chk("sb_pulse", 64'(out_valid_o), 64'd0);

        // Unsigned half at offset 2
        set_alloc(4, 3'b101, 3'd2, 1'b0);
        tick();
        set_rsp(4, 64'h0000_0000_ABCD_0000);
        tick();
        chk("uh_valid", 64'(out_valid_o), 64'd1);
        chk("uh_data",  out_data_o,       64'h0000_0000_0000_ABCD);

        // FP word with negative sign: identical under sign-extension and NaN-boxing
        set_alloc(6, 3'b010, 3'd4, 1'b1);
        tick();
        set_rsp(6, 64'h8765_4321_0000_0000);
        tick();
        chk("fpw_neg", out_data_o, 64'hFFFF_FFFF_8765_4321);

        // FP word with positive sign distinguishes the two builds
        set_alloc(6, 3'b010, 3'd0, 1'b1);
        tick();
        set_rsp(6, 64'h0000_0000_1234_5678);
        tick();
`ifdef DCACHE_RSP_NANBOX_EN
        chk("fpw_pos", out_data_o, 64'hFFFF_FFFF_1234_5678);
`else
        chk("fpw_pos", out_data_o, 64'h0000_0000_1234_5678);
`endif

        // Integer signed word and double
        set_alloc(2, 3'b010, 3'd4, 1'b0);
        tick();
        set_rsp(2, 64'h7FFF_0001_FFFF_FFFF);
        tick();
        chk("sw_data", out_data_o, 64'h0000_0000_7FFF_0001);
        set_alloc(2, 3'b011, 3'd0, 1'b0);
        tick();
        set_rsp(2, 64'hDEAD_BEEF_0123_4567);
        tick();
        chk("dw_data", out_data_o, 64'hDEAD_BEEF_0123_4567);
        chk("clean_err", 64'(err_o), 64'd0);

        // Fill to MAX_OUT, then overflow
        for (int i = 0; i < 8; i++) begin
            set_alloc(i, 3'b011, 3'd0, 1'b0);
            tick();
        end
        chk("full_pending", 64'(pending_o),   64'd8);
        chk("full_can",     64'(can_issue_o), 64'd0);
        chk("full_err0",    64'(err_o),       64'd0);
        set_alloc(8, 3'b011, 3'd0, 1'b0);
        tick();
        chk("ovf_err",     64'(err_o),     64'd1);
        chk("ovf_pending", 64'(pending_o), 64'd8);
        set_rsp(8, 64'h1);
        tick();
        chk("ovf_dropped", 64'(out_valid_o), 64'd0);
        do_reset();
        chk("rst2_err",     64'(err_o),       64'd0);
        chk("rst2_pending", 64'(pending_o),   64'd0);
        chk("rst2_can",     64'(can_issue_o), 64'd1);

        // Alloc tid7 and free tid1 in the same cycle
        set_alloc(0, 3'b011, 3'd0, 1'b0);
        tick();
        set_alloc(1, 3'b011, 3'd0, 1'b0);
        tick();
        chk("mix_pending2", 64'(pending_o), 64'd2);
        set_alloc(7, 3'b000, 3'd0, 1'b0);
        set_rsp(1, 64'h1122_3344_5566_7788);
        tick();
        chk("mix_pending", 64'(pending_o),   64'd2);
        chk("mix_valid",   64'(out_valid_o), 64'd1);
        chk("mix_tid",     64'(out_tid_o),   64'd1);
        chk("mix_data",    out_data_o,       64'h1122_3344_5566_7788);
        chk("mix_err",     64'(err_o),       64'd0);
        set_rsp(1, 64'h0);
        tick();
        chk("orphan_valid", 64'(out_valid_o), 64'd0);
        chk("orphan_err",   64'(err_o),       64'd1);
        do_reset();

        // Same tid alloc+rsp while busy: old fields used, alloc dropped
        set_alloc(2, 3'b000, 3'd0, 1'b0);
        tick();
        set_alloc(2, 3'b011, 3'd0, 1'b0);
        set_rsp(2, 64'h1234_5678_9ABC_FF7F);
        tick();
        chk("col_busy_valid",   64'(out_valid_o), 64'd1);
        chk("col_busy_data",    out_data_o,       64'h0000_0000_0000_007F);
        chk("col_busy_pending", 64'(pending_o),   64'd0);
        chk("col_busy_err",     64'(err_o),       64'd1);
        set_rsp(2, 64'h5);
        tick();
        chk("col_busy_freed", 64'(out_valid_o), 64'd0);
        do_reset();

        // Same tid alloc+rsp while free: alloc only, no bypass
        set_alloc(5, 3'b100, 3'd1, 1'b0);
        set_rsp(5, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("col_free_valid",   64'(out_valid_o), 64'd0);
        chk("col_free_pending", 64'(pending_o),   64'd1);
        chk("col_free_err",     64'(err_o),       64'd1);
        set_rsp(5, 64'h0000_0000_0000_9A00);
        tick();
        chk("col_free_later", 64'(out_valid_o), 64'd1);
        chk("col_free_data",  out_data_o,       64'h0000_0000_0000_009A);
        do_reset();

        // Orphan response, sticky error
        set_rsp(9, 64'hFF);
        tick();
        chk("r9_valid", 64'(out_valid_o), 64'd0);
        chk("r9_err",   64'(err_o),       64'd1);
        tick();
        tick();
        chk("r9_sticky", 64'(err_o), 64'd1);
        do_reset();
        chk("r9_clr", 64'(err_o), 64'd0);

        // Reset mid-flight discards outstanding entries
        set_alloc(3, 3'b011, 3'd0, 1'b0);
        tick();
        do_reset();
        set_rsp(3, 64'h42);
        tick();
        chk("midrst_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_err",   64'(err_o),       64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
